hub75_rx: RTL and testbench

HUB75_RX -- requirements
Module: hub75_rx

---
 rtl/hub75_pkg.sv | 54 +++++
 rtl/hub75_line_buf.sv | 37 +++
 rtl/hub75_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_hub75_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hub75_pkg                                              |
// | Purpose  : Shared constants, capture word layout and FSM states   |
// |            for the HUB75 panel receiver.                          |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package hub75_pkg;

  // Default column index width (line buffer holds 2**COL_W pixels)
  localparam int COL_W     = 9;
  // Highest bit-plane index reported for repeated latches of a row
  localparam int MAX_PLANE = 7;
  // Capture word width: plane + row + col + six colour bits
  localparam int CAP_W     = 23;

  // Field widths inside the capture word
  localparam int RGB_W     = 6;
  localparam int ROW_W     = 5;
  localparam int PLANE_W   = 3;
  localparam int CAP_COL_W = 9;

  // Field offsets inside the capture word
  localparam int CAP_RGB_LSB   = 0;
  localparam int CAP_COL_LSB   = CAP_RGB_LSB + RGB_W;
  localparam int CAP_ROW_LSB   = CAP_COL_LSB + CAP_COL_W;
  localparam int CAP_PLANE_LSB = CAP_ROW_LSB + ROW_W;

  // Receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } rx_state_e;

  // Plane number for a newly latched row: restart at 0 on a new row,
  // otherwise count up and stick at MAX_PLANE.
  function automatic logic [PLANE_W-1:0] next_plane(
    input logic [ROW_W-1:0]   row,
    input logic [ROW_W-1:0]   last_row,
    input logic [PLANE_W-1:0] last_plane
  );
    if (row != last_row) begin
      return '0;
    end else if (last_plane == PLANE_W'(MAX_PLANE)) begin
      return last_plane;
    end else begin
      return last_plane + PLANE_W'(1);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/hub75_line_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hub75_line_buf                                         |
// | Purpose  : Simple dual-port line buffer, one write and one        |
// |            registered read port on the same clock.                |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module hub75_line_buf #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage write plus one-cycle registered read; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hub75_rx                                               |
// | Purpose  : HUB75 panel sniffer. Synchronises the panel bus,       |
// |            stores one shifted row per latch in a line buffer and  |
// |            replays it as a ready/valid stream of tagged pixels.   |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COL_W       = hub75_pkg::COL_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CAP_COL_W-1:0] pixels_per_row,
  input  logic                 led_clk,
  input  logic                 latch_enable,
  input  logic                 plane_oe,
  input  logic [ROW_W-1:0]     abcde,
  input  logic                 r0,
  input  logic                 g0,
  input  logic                 b0,
  input  logic                 r1,
  input  logic                 g1,
  input  logic                 b1,
  output logic                 cap_valid,
  input  logic                 cap_ready,
  output logic [CAP_W-1:0]     cap_data,
  output logic                 len_err,
  output logic                 overrun
);

  // Bit positions of the panel signals inside the synchroniser vector
  localparam int SYNC_W     = 14;
  localparam int SB_LED     = 13;
  localparam int SB_LAT     = 12;
  localparam int SB_OE      = 11;
  localparam int SB_ROW_LSB = 6;
  localparam int SB_RGB_LSB = 0;

  localparam logic [COL_W-1:0] COL_MAX  = '1;
  localparam logic [ROW_W-1:0] ROW_NONE = '1;

  // Synchroniser chain and edge history
  logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q, sync_d;
  logic [SYNC_W-1:0]                  sync_out;
  logic                               led_prev_q, lat_prev_q;
  logic                               led_rise, lat_rise;
  logic [ROW_W-1:0]                   sync_row;
  logic [RGB_W-1:0]                   sync_rgb;
  logic                               unused_plane_oe;

  // Control and tracking state
  rx_state_e        state_q, state_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [COL_W-1:0] n_q, n_d;
  logic [COL_W-1:0] out_idx_q, out_idx_d;
  logic [ROW_W-1:0] last_row_q, last_row_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [PLANE_W-1:0] last_plane_q, last_plane_d;
  logic [PLANE_W-1:0] out_plane_q, out_plane_d;
  logic             valid_q, valid_d;
  logic             len_err_q, len_err_d;
  logic             overrun_q, overrun_d;
  logic [PLANE_W-1:0] latch_plane;

  // Line buffer ports
  logic             buf_wr_en;
  logic [RGB_W-1:0] buf_rd_data;

  // Shift register of panel samples: stage 0 takes the raw pins.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {led_clk, latch_enable, plane_oe, abcde, r0, g0, b0, r1, g1, b1};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops plus the previous-sample flops used for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      led_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      led_prev_q <= sync_out[SB_LED];
      lat_prev_q <= sync_out[SB_LAT];
    end
  end

  assign sync_out        = sync_q[SYNC_STAGES-1];
  assign sync_row        = sync_out[SB_ROW_LSB +: ROW_W];
  assign sync_rgb        = sync_out[SB_RGB_LSB +: RGB_W];
  assign led_rise        = sync_out[SB_LED] & ~led_prev_q;
  assign lat_rise        = sync_out[SB_LAT] & ~lat_prev_q;
  // Output enable is brought into the clock domain but not acted on yet.
  assign unused_plane_oe = sync_out[SB_OE];

  assign latch_plane = next_plane(sync_row, last_row_q, last_plane_q);

  // Next-state logic: capture in SHIFT, replay in FLUSH, enable low wipes all.
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    n_d          = n_q;
    out_idx_d    = out_idx_q;
    last_row_d   = last_row_q;
    last_plane_d = last_plane_q;
    out_row_d    = out_row_q;
    out_plane_d  = out_plane_q;
    valid_d      = valid_q;
    len_err_d    = len_err_q;
    overrun_d    = overrun_q;
    buf_wr_en    = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      col_cnt_d    = '0;
      out_idx_d    = '0;
      valid_d      = 1'b0;
      last_row_d   = ROW_NONE;
      last_plane_d = '0;
      len_err_d    = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
        end

        SHIFT: begin
          // Pixel shift: store until the buffer is full, then flag overrun.
          if (led_rise) begin
            if (col_cnt_q != COL_MAX) begin
              buf_wr_en = 1'b1;
              col_cnt_d = col_cnt_q + COL_W'(1);
            end else begin
              overrun_d = 1'b1;
            end
          end
          // Row latch: update plane tracking, check length, start replay.
          if (lat_rise) begin
            last_row_d   = sync_row;
            last_plane_d = latch_plane;
            out_row_d    = sync_row;
            out_plane_d  = latch_plane;
            if (CAP_COL_W'(col_cnt_q) != pixels_per_row) begin
              len_err_d = 1'b1;
            end
            if (col_cnt_q != '0) begin
              state_d   = FLUSH;
              n_d       = col_cnt_q;
              out_idx_d = '0;
              valid_d   = 1'b0;
            end
          end
        end

        FLUSH: begin
          // The buffer cannot accept new traffic while it is being replayed.
          if (led_rise || lat_rise) begin
            overrun_d = 1'b1;
          end
          if (!valid_q) begin
            // First FLUSH cycle lets the registered read of col 0 settle.
            valid_d = 1'b1;
          end else if (cap_ready) begin
            if (out_idx_q == n_q - COL_W'(1)) begin
              valid_d   = 1'b0;
              col_cnt_d = '0;
              out_idx_d = '0;
              state_d   = SHIFT;
            end else begin
              out_idx_d = out_idx_q + COL_W'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM and datapath registers; reset also kills any replay in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      n_q          <= '0;
      out_idx_q    <= '0;
      last_row_q   <= ROW_NONE;
      last_plane_q <= '0;
      out_row_q    <= '0;
      out_plane_q  <= '0;
      valid_q      <= 1'b0;
      len_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      n_q          <= n_d;
      out_idx_q    <= out_idx_d;
      last_row_q   <= last_row_d;
      last_plane_q <= last_plane_d;
      out_row_q    <= out_row_d;
      out_plane_q  <= out_plane_d;
      valid_q      <= valid_d;
      len_err_q    <= len_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Read address follows the next output index so data is ready with valid
  // and stays put while the consumer stalls.
  hub75_line_buf #(
    .ADDR_W (COL_W),
    .DATA_W (RGB_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (col_cnt_q),
    .wr_data (sync_rgb),
    .rd_addr (out_idx_d),
    .rd_data (buf_rd_data)
  );

  assign cap_valid = valid_q;
  // Word is forced to zero whenever it is not offered.
  assign cap_data  = valid_q ? {out_plane_q, out_row_q, CAP_COL_W'(out_idx_q), buf_rd_data}
                             : '0;
  assign len_err   = len_err_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_hub75_rx                                            |
// | Purpose  : Directed self-checking bench for hub75_rx with a       |
// |            scoreboard of expected capture words.                  |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_hub75_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  pixels_per_row;
  logic        led_clk, latch_enable, plane_oe;
  logic [4:0]  abcde;
  logic        r0, g0, b0, r1, g1, b1;
  logic        cap_valid;
  logic        cap_ready;
  logic [22:0] cap_data;
  logic        len_err, overrun;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_q [$];
  logic [5:0]  pix_q [$];

  int          acc_cnt      = 0;
  bit          seen_valid   = 1'b0;
  bit          hold_pending = 1'b0;
  logic [22:0] hold_data    = '0;

  hub75_rx #(
    .COL_W       (9),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .pixels_per_row (pixels_per_row),
    .led_clk        (led_clk),
    .latch_enable   (latch_enable),
    .plane_oe       (plane_oe),
    .abcde          (abcde),
    .r0             (r0),
    .g0             (g0),
    .b0             (b0),
    .r1             (r1),
    .g1             (g1),
    .b1             (b1),
    .cap_valid      (cap_valid),
    .cap_ready      (cap_ready),
    .cap_data       (cap_data),
    .len_err        (len_err),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks stalls.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (cap_valid) seen_valid = 1'b1;
      if (hold_pending) begin
        check("stall_hold", {8'h0, cap_valid, cap_data}, {8'h0, 1'b1, hold_data});
      end
      hold_pending = 1'b0;
      if (cap_valid && cap_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_word: observed %0h expected none", cap_data);
        end
        if (exp_q.size() > 0) begin
          check($sformatf("word_%0d", acc_cnt), {9'h0, cap_data}, {9'h0, exp_q.pop_front()});
        end
        acc_cnt++;
      end else if (cap_valid) begin
        hold_pending = 1'b1;
        hold_data    = cap_data;
      end
    end
  end

  task automatic pulse_led(input logic [5:0] rgb, input bit record);
    @(posedge clk);
    #1;
    {r0, g0, b0, r1, g1, b1} = rgb;
    if (record) pix_q.push_back(rgb);
    repeat (2) @(posedge clk);
    #1;
    led_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    led_clk = 1'b0;
  endtask

  task automatic do_latch(input logic [4:0] row, input logic [2:0] exp_plane);
    @(posedge clk);
    #1;
    abcde = row;
    foreach (pix_q[i]) exp_q.push_back({exp_plane, row, 9'(i), pix_q[i]});
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1;
    latch_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    latch_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [3:0] pat, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || cap_valid) && n < 3000) begin
      cap_ready = pat[n % 4];
      @(posedge clk);
      #1;
      n++;
    end
    cap_ready = 1'b1;
    check({tag, "_drain_done"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic send_row(input logic [4:0] row, input int npix, input logic [2:0] exp_plane);
    for (int k = 0; k < npix; k++) pulse_led(6'($urandom_range(0, 63)), 1'b1);
    do_latch(row, exp_plane);
    drain(4'b1111, $sformatf("row%0d_p%0d", row, exp_plane));
  endtask

  task automatic toggle_enable();
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; pixels_per_row = 9'd64;
    led_clk = 1'b0; latch_enable = 1'b0; plane_oe = 1'b0; abcde = '0;
    {r0, g0, b0, r1, g1, b1} = '0; cap_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_valid",   32'(cap_valid), 32'd0);
    check("rst_data",    32'(cap_data),  32'd0);
    check("rst_len_err", 32'(len_err),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full 64-pixel row, rgb = col, row 3, first plane
    for (int k = 0; k < 64; k++) pulse_led(6'(k), 1'b1);
    do_latch(5'd3, 3'd0);
    drain(4'b1111, "full_row");
    check("full_len_err", 32'(len_err), 32'd0);
    check("full_overrun", 32'(overrun), 32'd0);

    // Consumer stalls 1-0-0-1 during replay
    pixels_per_row = 9'd8;
    cap_ready = 1'b0;
    for (int k = 0; k < 8; k++) pulse_led(6'($urandom_range(0, 63)), 1'b1);
    do_latch(5'd7, 3'd0);
    drain(4'b1001, "stall");
    check("stall_len_err", 32'(len_err), 32'd0);

    // Plane tracking
    toggle_enable();
    pixels_per_row = 9'd4;
    for (int p = 0; p < 4; p++) send_row(5'd3, 4, 3'(p));
    send_row(5'd4, 4, 3'd0);
    for (int p = 0; p < 9; p++) send_row(5'd5, 4, (p > 7) ? 3'd7 : 3'(p));
    check("planes_len_err", 32'(len_err), 32'd0);

    // Latches with no shifted pixels
    seen_valid = 1'b0;
    do_latch(5'd6, 3'd0);
    do_latch(5'd6, 3'd1);
    repeat (5) @(posedge clk);
    #1;
    check("zero_no_valid", 32'(seen_valid), 32'd0);
    check("zero_len_err",  32'(len_err),    32'd1);
    send_row(5'd6, 4, 3'd2);
    toggle_enable();
    check("en_low_len_err", 32'(len_err), 32'd0);
    check("en_low_overrun", 32'(overrun), 32'd0);

    // Short row plus a shift during replay
    pixels_per_row = 9'd64;
    cap_ready = 1'b0;
    for (int k = 0; k < 40; k++) pulse_led(6'($urandom_range(0, 63)), 1'b1);
    do_latch(5'd9, 3'd0);
    check("short_in_flush", 32'(cap_valid), 32'd1);
    pulse_led(6'h2A, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("short_overrun", 32'(overrun), 32'd1);
    drain(4'b1111, "short");
    check("short_len_err", 32'(len_err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("short_len_err_sticky", 32'(len_err), 32'd1);

    // Reset in the middle of a replay
    cap_ready = 1'b1;
    for (int k = 0; k < 64; k++) pulse_led(~6'(k), 1'b1);
    acc_cnt = 0;
    do_latch(5'd3, 3'd0);
    n = 0;
    while (acc_cnt < 10 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_acc_cnt",  32'(acc_cnt),   32'd10);
    check("mid_valid_on", 32'(cap_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid",   32'(cap_valid), 32'd0);
    check("mid_rst_data",    32'(cap_data),  32'd0);
    check("mid_rst_len_err", 32'(len_err),   32'd0);
    check("mid_rst_overrun", 32'(overrun),   32'd0);
    exp_q.delete();
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) pulse_led(6'(k) ^ 6'h15, 1'b1);
    do_latch(5'd3, 3'd0);
    drain(4'b1111, "after_rst");
    check("after_rst_len_err", 32'(len_err), 32'd0);
    check("after_rst_overrun", 32'(overrun), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
